// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam logic [1:0] MW_BYTE = 2'd0;
   localparam logic [1:0] MW_HALF = 2'd1;
   localparam logic [1:0] MW_WORD = 2'd2;
   localparam logic [1:0] MW_ILL  = 2'd3;

   localparam logic [1:0] FLT_NONE = 2'd0;
   localparam logic [1:0] FLT_MIS  = 2'd1;
   localparam logic [1:0] FLT_TMO  = 2'd2;
   localparam logic [1:0] FLT_SIZE = 2'd3;

   typedef enum logic [1:0] {
      LSU_IDLE  = 2'd0,
      LSU_BUS   = 2'd1,
      LSU_RESP  = 2'd2,
      LSU_FAULT = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Pure combinational lane logic: strobes, store replication, load extract/extend,
// and the misalignment check.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        memrw,
   input  logic [1:0]  memword,
   input  logic        memsign,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_rdata,
   output logic        misaligned,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_lane,
   output logic [31:0] ld_data
);

   logic [3:0]  strb;
   logic [31:0] lane;

   always_comb begin
      misaligned = ((memword == MW_HALF) && addr_lo[0]) ||
                   ((memword == MW_WORD) && (addr_lo != 2'b00));

      strb       = 4'b0000;
      wdata_lane = wdata;
      case (memword)
         MW_BYTE: begin
            strb       = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         MW_HALF: begin
            strb       = 4'b0011 << addr_lo;
            wdata_lane = {2{wdata[15:0]}};
         end
         MW_WORD: strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      wstrb = memrw ? strb : 4'b0000;

      lane = bus_rdata >> {addr_lo, 3'b000};
      case (memword)
         MW_BYTE: ld_data = memsign ? {24'h0, lane[7:0]}
                                    : {{24{lane[7]}}, lane[7:0]};
         MW_HALF: ld_data = memsign ? {16'h0, lane[15:0]}
                                    : {{16{lane[15]}}, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM: latches a core request, runs one bus beat with a
// ready timeout, and reports completion/fault with a single done pulse.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        memrw,
   input  logic [1:0]  memword,
   input  logic        memsign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  fault,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   lsu_req_t    req_q, live, sel;
   logic [15:0] cnt_q;
   logic [1:0]  code_q;
   logic [31:0] cap_q;

   logic        a_mis;
   logic [3:0]  a_wstrb;
   logic [31:0] a_wdata, a_ld;

   assign live = '{rw: memrw, size: memword, sign: memsign, addr: addr, wdata: wdata};
   // In IDLE the align block judges the incoming request; afterwards it works
   // from the latched copy so bus outputs stay stable.
   assign sel  = (state_q == LSU_IDLE) ? live : req_q;

   lsu_align u_align (
      .memrw      (sel.rw),
      .memword    (sel.size),
      .memsign    (sel.sign),
      .addr_lo    (sel.addr[1:0]),
      .wdata      (sel.wdata),
      .bus_rdata  (bus_rdata),
      .misaligned (a_mis),
      .wstrb      (a_wstrb),
      .wdata_lane (a_wdata),
      .ld_data    (a_ld)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: begin
            if (req) begin
               if (memword == MW_ILL || a_mis) state_d = LSU_FAULT;
               else                            state_d = LSU_BUS;
            end
         end
         LSU_BUS: begin
            if (bus_ready)              state_d = LSU_RESP;
            else if (cnt_q == TMO_LAST) state_d = LSU_FAULT;
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LSU_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         code_q  <= FLT_NONE;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            LSU_IDLE: begin
               if (req) begin
                  req_q  <= live;
                  cnt_q  <= '0;
                  code_q <= (memword == MW_ILL) ? FLT_SIZE :
                            a_mis               ? FLT_MIS  : FLT_NONE;
               end
            end
            LSU_BUS: begin
               if (bus_ready)              cap_q  <= req_q.rw ? 32'h0 : a_ld;
               else if (cnt_q == TMO_LAST) code_q <= FLT_TMO;
               else                        cnt_q  <= cnt_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus_valid = (state_q == LSU_BUS);
   assign bus_we    = bus_valid & req_q.rw;
   assign bus_addr  = bus_valid ? {req_q.addr[31:2], 2'b00} : 32'h0;
   assign bus_wstrb = bus_valid ? a_wstrb : 4'b0000;
   assign bus_wdata = bus_valid ? a_wdata : 32'h0;

   assign stall = ((state_q == LSU_IDLE) & req) | (state_q == LSU_BUS);
   assign done  = (state_q == LSU_RESP) | (state_q == LSU_FAULT);
   assign fault = (state_q == LSU_FAULT) ? code_q : FLT_NONE;
   assign rdata = (state_q == LSU_RESP) ? cap_q : 32'h0;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit for the single-cycle RV32I datapath. It is the consumer of the control unit's memory controls (`memrw`, `memword`, `memsign`).
- Takes one load or store request from the core. It checks alignment, drives a word-wide valid/ready data bus with byte strobes, and aligns and extends read data.
- Stalls the core until the access completes or faults.
- Sits between the ALU address output / rs2 data and the writeback mux (`WB_MEM` path).

Parameters:
- TIMEOUT, 255: bus_ready wait limit in cycles before a bus-error fault. Range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  1  access request from core; held stable until done
- memrw  in  1  0 = read (MEM_READ), 1 = write (MEM_WRITE)
- memword  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- memsign  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  core must hold PC/regs
- done  out  1  one-cycle completion pulse
- rdata  out  32  aligned, extended load data; valid when done & !memrw
- fault  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal size; valid when done
- bus_valid  out  1  bus request
- bus_we  out  1  write enable
- bus_addr  out  32  word address; addr[1:0] forced to 0
- bus_wstrb  out  4  byte-lane strobes
- bus_wdata  out  32  lane-shifted store data
- bus_ready  in  1  bus accepts/completes the beat
- bus_rdata  in  32  read word; valid with bus_ready

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset mid-operation: next edge returns to IDLE and drops bus_valid. No done is issued.
- States and transitions:
  - IDLE: on req, register addr, wdata, memrw, memword and memsign.
    - memword==3 goes to FAULT with code 3.
    - Misaligned access goes to FAULT with code 1. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
    - Otherwise go to BUS.
  - BUS: bus_valid=1, with bus_we, bus_addr, bus_wstrb and bus_wdata stable from registers.
    - On bus_ready: capture the aligned read result and go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready, go to FAULT with code 2 and deassert bus_valid.
  - RESP: done=1, fault=0, rdata driven from the capture register; next state IDLE.
  - FAULT: done=1 and fault=code for one cycle; rdata=0; no bus activity ever issued; next state IDLE.
- stall = req in IDLE, or state is BUS. stall is low in RESP and FAULT (the completion cycle).
- Minimum latency: req at cycle 0, bus_valid at cycle 1, bus_ready at cycle 1, done at cycle 2.
- A new req in the cycle after done is accepted normally. The core deasserts req or presents the next request.
- Strobes:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Strobes are 0 when memrw=0.
- bus_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Read alignment:
  - Select the lane as bus_rdata >> (8*addr[1:0]).
  - Byte: extend bit 7 (or zero-fill when memsign=1). Half: extend bit 15 (or zero-fill when memsign=1).
  - The timeout counter clears on every IDLE→BUS transition.
- req dropped while in BUS: the access still completes. The bus handshake is never abandoned except on timeout.

Decomposition:
- Constants in const.h:
  - MEM_READ and MEM_WRITE.
  - Size codes MW_BYTE=0, MW_HALF=1, MW_WORD=2.
  - Fault codes FLT_NONE, FLT_MIS, FLT_TMO, FLT_SIZE.
  - State encodings LSU_IDLE, LSU_BUS, LSU_RESP, LSU_FAULT.
- One combinational sub-module, lsu_align, covers strobe/wdata generation, read-lane extraction and extension, and the misalignment check.
- lsu contains only the FSM, registers and the counter.

Test Plan:
- Store byte: addr=0x1003, wdata=0xAB, memword=0, memrw=1, ready after 1 cycle → bus_addr=0x1000, wstrb=4'b1000, bus_wdata=0xABABABAB, done at cycle 2, fault=0.
- Signed byte load: addr=0x2001, memsign=0, bus_rdata=0x00008000 → rdata=0xFFFFFF80. With memsign=1 → rdata=0x00000080.
- Half load: addr=0x2002, bus_rdata=0x9ABC1234, memsign=0 → rdata=0xFFFF9ABC.
- Misaligned word: addr=0x3002, memword=2 → bus_valid never asserts, done one cycle later with fault=1.
- Timeout: TIMEOUT=4, bus_ready held 0 → bus_valid high for exactly 4 cycles, then done with fault=2. A following request at 0x4000 with ready completes normally.
- Wait states and reset: ready delayed 3 cycles → stall high for 4 cycles, then done. Assert rst in BUS → bus_valid=0 next cycle, no done, state IDLE.
